// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR command-port arbiter.
// State encodings are fixed constants so the enum stays bit-compatible with older netlists.
package ddr_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE
    } arb_state_e;

    localparam logic GNT_WR = 1'b1;
    localparam logic GNT_RD = 1'b0;

    localparam int WR_BURST_MAX_DEF = 8;
    localparam int RD_BURST_MAX_DEF = 2;

endpackage

// File: rtl/ddr_req_arbiter_if.sv
// Bundle of the write requester, read requester and memory command handshakes.
interface ddr_req_arbiter_if #(
    parameter int ADX_W  = 27,
    parameter int DATA_W = 128
);
    logic              wr_req;
    logic [ADX_W-1:0]  wr_adx;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic              rd_req;
    logic [ADX_W-1:0]  rd_adx;
    logic              rd_ack;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADX_W-1:0]  cmd_adx;
    logic [DATA_W-1:0] cmd_data;

    // Arbiter side
    modport slave (
        input  wr_req, wr_adx, wr_data, rd_req, rd_adx, cmd_ready,
        output wr_ack, rd_ack, cmd_valid, cmd_write, cmd_adx, cmd_data
    );

    // Requester / memory-interface side
    modport master (
        output wr_req, wr_adx, wr_data, rd_req, rd_adx, cmd_ready,
        input  wr_ack, rd_ack, cmd_valid, cmd_write, cmd_adx, cmd_data
    );

endinterface

// File: rtl/ddr_arb_policy.sv
// Write-priority winner select with saturating streak counters that bound starvation
// of whichever requester is waiting.
module ddr_arb_policy
    import ddr_arb_pkg::*;
#(
    parameter int WR_BURST_MAX = WR_BURST_MAX_DEF,
    parameter int RD_BURST_MAX = RD_BURST_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic wr_req,
    input  logic rd_req,
    input  logic last_grant,
    input  logic grant,
    output logic winner
);

    localparam int WR_SW = $clog2(WR_BURST_MAX + 1);
    localparam int RD_SW = $clog2(RD_BURST_MAX + 1);
    localparam logic [WR_SW-1:0] WR_LIM = WR_SW'(WR_BURST_MAX);
    localparam logic [RD_SW-1:0] RD_LIM = RD_SW'(RD_BURST_MAX);

    logic [WR_SW-1:0] wr_streak;
    logic [RD_SW-1:0] rd_streak;

    // An unfinished read burst keeps priority; otherwise writes win until their streak saturates.
    always_comb begin
        winner = GNT_WR;
        if (!wr_req) begin
            winner = GNT_RD;
        end else if (rd_req) begin
            if (last_grant == GNT_RD && rd_streak < RD_LIM) begin
                winner = GNT_RD;
            end else if (wr_streak == WR_LIM) begin
                winner = GNT_RD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_streak <= '0;
            rd_streak <= '0;
        end else if (grant) begin
            if (winner == GNT_WR) begin
                rd_streak <= '0;
                if (!rd_req) begin
                    wr_streak <= '0;
                end else if (wr_streak != WR_LIM) begin
                    wr_streak <= wr_streak + WR_SW'(1);
                end
            end else begin
                wr_streak <= '0;
                if (!wr_req) begin
                    rd_streak <= '0;
                end else if (rd_streak != RD_LIM) begin
                    rd_streak <= rd_streak + RD_SW'(1);
                end
            end
        end else if (idle) begin
            if (!rd_req) wr_streak <= '0;
            if (!wr_req) rd_streak <= '0;
        end
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Shares the DDR command port between the sample write path and the capture readback path.
//
//   state | meaning
//   IDLE  | no command outstanding; requests are sampled and arbitrated
//   ISSUE | command held on cmd_*, waiting for cmd_ready; requests ignored
module ddr_req_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADX_W        = 27,
    parameter int DATA_W       = 128,
    parameter int WR_BURST_MAX = WR_BURST_MAX_DEF,
    parameter int RD_BURST_MAX = RD_BURST_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    ddr_req_arbiter_if.slave   bus,
    output logic               busy
);

    arb_state_e        state;
    logic              last_grant;
    logic              grant;
    logic              winner;
    logic              cmd_valid_q;
    logic              cmd_write_q;
    logic              wr_ack_q;
    logic              rd_ack_q;
    logic [ADX_W-1:0]  cmd_adx_q;
    logic [DATA_W-1:0] cmd_data_q;

    assign grant = (state == IDLE) && (bus.wr_req || bus.rd_req);
    assign busy  = (state != IDLE);

    ddr_arb_policy #(
        .WR_BURST_MAX (WR_BURST_MAX),
        .RD_BURST_MAX (RD_BURST_MAX)
    ) u_policy (
        .clk        (clk),
        .reset      (reset),
        .idle       (state == IDLE),
        .wr_req     (bus.wr_req),
        .rd_req     (bus.rd_req),
        .last_grant (last_grant),
        .grant      (grant),
        .winner     (winner)
    );

    // last_grant starts as a write so the first contended grant after reset follows write priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= GNT_WR;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            cmd_adx_q   <= '0;
            cmd_data_q  <= '0;
        end else begin
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state       <= ISSUE;
                        cmd_valid_q <= 1'b1;
                        cmd_write_q <= winner;
                        last_grant  <= winner;
                        if (winner == GNT_WR) begin
                            cmd_adx_q  <= bus.wr_adx;
                            cmd_data_q <= bus.wr_data;
                            wr_ack_q   <= 1'b1;
                        end else begin
                            cmd_adx_q  <= bus.rd_adx;
                            rd_ack_q   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        state       <= IDLE;
                        cmd_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_write = cmd_write_q;
    assign bus.cmd_adx   = cmd_adx_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_ack    = rd_ack_q;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Self-checking bench for ddr_req_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_ddr_req_arbiter;

    localparam int ADX_W  = 27;
    localparam int DATA_W = 128;
    localparam int WR_MAX = 8;
    localparam int RD_MAX = 2;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    ddr_req_arbiter_if #(.ADX_W(ADX_W), .DATA_W(DATA_W)) bus ();

    ddr_req_arbiter #(
        .ADX_W        (ADX_W),
        .DATA_W       (DATA_W),
        .WR_BURST_MAX (WR_MAX),
        .RD_BURST_MAX (RD_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit                m_idle;
    bit                m_last_wr;
    int                m_wr_streak;
    int                m_rd_streak;
    logic              m_valid;
    logic              m_write;
    logic              m_wr_ack;
    logic              m_rd_ack;
    logic [ADX_W-1:0]  m_adx;
    logic [DATA_W-1:0] m_data;

    logic [DATA_W-1:0] pat_a5;

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_idle = 1; m_last_wr = 1; m_wr_streak = 0; m_rd_streak = 0;
        m_valid = 0; m_write = 0; m_wr_ack = 0; m_rd_ack = 0; m_adx = '0; m_data = '0;
    endtask

    // Advance the model using the inputs present at the coming edge, then step to edge+1.
    task automatic tick();
        bit g_wr;
        if (reset) begin
            model_reset();
        end else begin
            m_wr_ack = 0;
            m_rd_ack = 0;
            if (m_idle) begin
                if (bus.wr_req || bus.rd_req) begin
                    if (!bus.rd_req)                               g_wr = 1;
                    else if (!bus.wr_req)                          g_wr = 0;
                    else if (!m_last_wr && m_rd_streak < RD_MAX)   g_wr = 0;
                    else                                           g_wr = (m_wr_streak != WR_MAX);
                    m_idle = 0; m_valid = 1; m_write = g_wr; m_last_wr = g_wr;
                    if (g_wr) begin
                        m_adx = bus.wr_adx; m_data = bus.wr_data; m_wr_ack = 1;
                        m_wr_streak = bus.rd_req ? ((m_wr_streak < WR_MAX) ? m_wr_streak + 1 : WR_MAX) : 0;
                        m_rd_streak = 0;
                    end else begin
                        m_adx = bus.rd_adx; m_rd_ack = 1;
                        m_rd_streak = bus.wr_req ? ((m_rd_streak < RD_MAX) ? m_rd_streak + 1 : RD_MAX) : 0;
                        m_wr_streak = 0;
                    end
                end else begin
                    m_wr_streak = 0;
                    m_rd_streak = 0;
                end
            end else if (bus.cmd_ready) begin
                m_idle = 1; m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        bus.wr_req = 0; bus.rd_req = 0; bus.cmd_ready = 1;
        bus.wr_adx = '0; bus.rd_adx = '0; bus.wr_data = '0;
        model_reset();
        tick(); tick();
        checks++;
        if ({bus.cmd_valid, bus.cmd_write, bus.wr_ack, bus.rd_ack, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b write=%b wr_ack=%b rd_ack=%b busy=%b, want all 0",
                     bus.cmd_valid, bus.cmd_write, bus.wr_ack, bus.rd_ack, busy);
        end
        checks++;
        if (bus.cmd_adx !== '0 || bus.cmd_data !== '0) begin
            errors++;
            $display("FAIL reset_cmd: got adx=%h data=%h, want 0", bus.cmd_adx, bus.cmd_data);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_lone_write();
        bus.cmd_ready = 1;
        bus.wr_req = 1; bus.wr_adx = 27'h0000010; bus.wr_data = pat_a5;
        tick();
        checks++;
        if ({bus.cmd_valid, bus.cmd_write, bus.wr_ack, bus.rd_ack, busy} !== 5'b11101) begin
            errors++;
            $display("FAIL lone_write_ctrl: got valid=%b write=%b wr_ack=%b rd_ack=%b busy=%b, want 1 1 1 0 1",
                     bus.cmd_valid, bus.cmd_write, bus.wr_ack, bus.rd_ack, busy);
        end
        checks++;
        if (bus.cmd_adx !== 27'h10 || bus.cmd_data !== pat_a5) begin
            errors++;
            $display("FAIL lone_write_cmd: got adx=%h data=%h, want adx=10 data=%h", bus.cmd_adx, bus.cmd_data, pat_a5);
        end
        bus.wr_req = 0;
        tick();
        checks++;
        if ({bus.cmd_valid, bus.wr_ack, busy} !== 3'b000) begin
            errors++;
            $display("FAIL lone_write_done: got valid=%b wr_ack=%b busy=%b, want 0 0 0", bus.cmd_valid, bus.wr_ack, busy);
        end
    endtask

    task automatic test_backpressure();
        int acks;
        bus.cmd_ready = 0;
        bus.rd_req = 1; bus.rd_adx = 27'h40;
        tick();
        acks = int'(bus.rd_ack);
        bus.rd_req = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.cmd_valid !== 1'b1 || bus.cmd_write !== 1'b0 || bus.cmd_adx !== 27'h40 || busy !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got valid=%b write=%b adx=%h busy=%b, want 1 0 40 1",
                         i, bus.cmd_valid, bus.cmd_write, bus.cmd_adx, busy);
            end
            tick();
            acks += int'(bus.rd_ack);
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL backpressure_acks: got %0d rd_ack pulses, want 1", acks);
        end
        checks++;
        if (bus.cmd_data !== pat_a5) begin
            errors++;
            $display("FAIL read_keeps_data: got data=%h, want %h", bus.cmd_data, pat_a5);
        end
        bus.cmd_ready = 1;
        tick();
        checks++;
        if (bus.cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got valid=%b busy=%b, want 0 0", bus.cmd_valid, busy);
        end
    endtask

    task automatic test_write_starvation();
        bit seq[$];
        int n;
        bus.cmd_ready = 1;
        bus.rd_req = 0; bus.wr_req = 1;
        bus.wr_adx = 27'h100; bus.wr_data = rand_data();
        tick();
        checks++;
        if (bus.wr_ack !== 1'b1 || bus.cmd_write !== 1'b1) begin
            errors++;
            $display("FAIL starve_lead_write: got wr_ack=%b write=%b, want 1 1", bus.wr_ack, bus.cmd_write);
        end
        bus.wr_adx = ADX_W'($urandom); bus.wr_data = rand_data();
        bus.rd_req = 1; bus.rd_adx = ADX_W'($urandom);
        n = 0;
        while (seq.size() < 20 && n < 100) begin
            tick();
            n++;
            if (bus.wr_ack || bus.rd_ack) begin
                seq.push_back(bus.cmd_write);
                if (bus.wr_ack) begin bus.wr_adx = ADX_W'($urandom); bus.wr_data = rand_data(); end
                else            bus.rd_adx = ADX_W'($urandom);
            end
        end
        checks++;
        if (seq.size() != 20) begin
            errors++;
            $display("FAIL starve_timeout: got %0d grants in %0d cycles, want 20", seq.size(), n);
        end
        for (int k = 0; k < seq.size(); k++) begin
            checks++;
            if (seq[k] !== ((k % 10) < 8)) begin
                errors++;
                $display("FAIL starve_grant[%0d]: got write=%b, want %b", k, seq[k], ((k % 10) < 8));
            end
        end
        bus.wr_req = 0; bus.rd_req = 0;
        tick(); tick();
    endtask

    task automatic test_reads_only();
        int n;
        bus.cmd_ready = 1; bus.wr_req = 0; bus.rd_req = 1;
        for (int k = 0; k < 4; k++) begin
            bus.rd_adx = ADX_W'(k);
            n = 0;
            do begin
                tick();
                n++;
            end while (!bus.rd_ack && !bus.wr_ack && n < 5);
            checks++;
            if (bus.rd_ack !== 1'b1 || bus.cmd_write !== 1'b0 || bus.cmd_adx !== ADX_W'(k)) begin
                errors++;
                $display("FAIL reads_only[%0d]: got rd_ack=%b write=%b adx=%h, want 1 0 %h",
                         k, bus.rd_ack, bus.cmd_write, bus.cmd_adx, ADX_W'(k));
            end
            checks++;
            if (dut.u_policy.rd_streak !== '0) begin
                errors++;
                $display("FAIL reads_only_streak[%0d]: got rd_streak=%0d, want 0", k, dut.u_policy.rd_streak);
            end
        end
        bus.rd_req = 0;
        tick(); tick();
    endtask

    task automatic test_async_reset();
        bus.cmd_ready = 0;
        bus.wr_req = 1; bus.wr_adx = 27'h7654321; bus.wr_data = rand_data();
        tick();
        checks++;
        if (bus.wr_ack !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: got wr_ack=%b busy=%b, want 1 1", bus.wr_ack, busy);
        end
        #2;
        reset = 1;
        #1;
        model_reset();
        checks++;
        if ({bus.cmd_valid, bus.wr_ack, bus.rd_ack, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL async_drop: got valid=%b wr_ack=%b rd_ack=%b busy=%b, want all 0",
                     bus.cmd_valid, bus.wr_ack, bus.rd_ack, busy);
        end
        checks++;
        if (dut.u_policy.wr_streak !== '0 || dut.u_policy.rd_streak !== '0 || bus.cmd_adx !== '0) begin
            errors++;
            $display("FAIL async_counters: got wr_streak=%0d rd_streak=%0d adx=%h, want 0",
                     dut.u_policy.wr_streak, dut.u_policy.rd_streak, bus.cmd_adx);
        end
        bus.wr_req = 0; bus.rd_req = 0; bus.cmd_ready = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || bus.cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL async_stay_idle[%0d]: got busy=%b valid=%b, want 0 0", i, busy, bus.cmd_valid);
            end
        end
    endtask

    task automatic test_withdrawn();
        int rd_acks;
        bus.cmd_ready = 0;
        bus.wr_req = 1; bus.wr_adx = 27'h55; bus.wr_data = rand_data();
        tick();
        rd_acks = 0;
        bus.wr_req = 0; bus.rd_req = 1; bus.rd_adx = 27'h66;
        tick();
        rd_acks += int'(bus.rd_ack);
        bus.rd_req = 0; bus.cmd_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            rd_acks += int'(bus.rd_ack);
        end
        checks++;
        if (rd_acks !== 0) begin
            errors++;
            $display("FAIL withdrawn_ack: got %0d rd_ack pulses, want 0", rd_acks);
        end
        checks++;
        if (bus.cmd_valid !== 1'b0 || bus.cmd_write !== 1'b1 || bus.cmd_adx !== 27'h55) begin
            errors++;
            $display("FAIL withdrawn_cmd: got valid=%b write=%b adx=%h, want 0 1 55",
                     bus.cmd_valid, bus.cmd_write, bus.cmd_adx);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.cmd_ready = ($urandom_range(0, 9) < 7);
            tick();
            checks++;
            if ({bus.cmd_valid, bus.cmd_write, bus.wr_ack, bus.rd_ack, busy} !== {m_valid, m_write, m_wr_ack, m_rd_ack, !m_idle}
                || bus.cmd_adx !== m_adx || bus.cmd_data !== m_data) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b w=%b wa=%b ra=%b busy=%b adx=%h data=%h, want v=%b w=%b wa=%b ra=%b busy=%b adx=%h data=%h",
                         c, bus.cmd_valid, bus.cmd_write, bus.wr_ack, bus.rd_ack, busy, bus.cmd_adx, bus.cmd_data,
                         m_valid, m_write, m_wr_ack, m_rd_ack, !m_idle, m_adx, m_data);
            end
            // requesters: hold until ack, occasionally withdraw, re-request with fresh payload
            if (bus.wr_ack || !bus.wr_req) begin
                bus.wr_req = ($urandom_range(0, 9) < 8);
                bus.wr_adx = ADX_W'($urandom); bus.wr_data = rand_data();
            end else if ($urandom_range(0, 29) == 0) begin
                bus.wr_req = 0;
            end
            if (bus.rd_ack || !bus.rd_req) begin
                bus.rd_req = ($urandom_range(0, 9) < 6);
                bus.rd_adx = ADX_W'($urandom);
            end else if ($urandom_range(0, 29) == 0) begin
                bus.rd_req = 0;
            end
        end
        bus.wr_req = 0; bus.rd_req = 0; bus.cmd_ready = 1;
        tick(); tick();
    endtask

    initial begin
        pat_a5 = {16{8'hA5}};
        test_reset();
        test_lone_write();
        test_backpressure();
        test_write_starvation();
        test_reads_only();
        test_async_reset();
        test_withdrawn();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/ddr_req_arbiter.md
Name: ddr_req_arbiter

Overview:
- Shares the single command port of the DDR memory interface between two requesters: the sample write path (DRAM data packer) and the sample readback path (logic capture readback).
- Sits between the packer/logic-capture blocks and the memory interface, in the soc_clk domain.
- Arbitration is write-priority so live capture data is never dropped, with bounded starvation in both directions.

Parameters:
- ADX_W, 27, address width of wr_adx, rd_adx and cmd_adx.
- DATA_W, 128, width of wr_data and cmd_data.
- WR_BURST_MAX, 8, consecutive write grants allowed while rd_req waits; then one read is forced.
- RD_BURST_MAX, 2, consecutive read grants allowed while wr_req waits; then one write is forced.

Ports:
- clk  in  1  soc clock; the block has one clock.
- reset  in  1  asynchronous, active-high reset.
- wr_req  in  1  write request, level; held until wr_ack is seen.
- wr_adx  in  ADX_W  write address, valid while wr_req is high.
- wr_data  in  DATA_W  write data, valid while wr_req is high.
- wr_ack  out  1  one-cycle pulse: write captured.
- rd_req  in  1  read request, level; held until rd_ack is seen.
- rd_adx  in  ADX_W  read address, valid while rd_req is high.
- rd_ack  out  1  one-cycle pulse: read captured.
- cmd_valid  out  1  command presented to the memory interface.
- cmd_ready  in  1  memory interface accepts the command (write_allowed/read_allowed, muxed by the integrator).
- cmd_write  out  1  1 = write command, 0 = read command.
- cmd_adx  out  ADX_W  command address.
- cmd_data  out  DATA_W  command write data; holds last write data on reads.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - cmd_valid, cmd_write, wr_ack, rd_ack, busy = 0.
  - cmd_adx, cmd_data = 0.
  - wr_streak, rd_streak = 0.
  - An in-flight command is discarded; requesters must re-request.
- FSM states: IDLE, ISSUE.
- IDLE:
  - If either req is high at a rising edge, select a winner per the policy below.
  - On the same edge: latch adx (and data for writes) into the cmd_* registers, set cmd_write, set cmd_valid=1, pulse the winner's ack, and go to ISSUE.
  - Latency: request seen -> cmd_valid/ack = 1 cycle.
- ISSUE:
  - Requests are not sampled.
  - cmd_* stays stable while cmd_valid && !cmd_ready.
  - On an edge with cmd_ready=1: cmd_valid=0, go to IDLE.
  - Peak throughput is 1 command per 2 cycles.
- ack timing:
  - ack is high exactly during the first ISSUE cycle.
  - A requester seeing ack drops its req (or presents new adx/data) at the next edge.
  - req high in the cycle after ack is a new request.
- Policy, evaluated in IDLE:
  - Only wr_req: grant write.
  - Only rd_req: grant read.
  - Both high: grant write unless wr_streak==WR_BURST_MAX, in which case grant read.
  - Exception: if rd_streak<RD_BURST_MAX and the previous grant was a read, grant read.
  - Net effect: reads may continue until rd_streak reaches RD_BURST_MAX, then a write is forced.
- Streak counters, each $clog2(MAX+1) bits, saturating:
  - wr_streak: +1 on a write grant while rd_req is high; cleared on a read grant or on any IDLE cycle with rd_req low.
  - rd_streak: +1 on a read grant while wr_req is high; cleared on a write grant or on any IDLE cycle with wr_req low.
- Boundary cases:
  - cmd_ready high while cmd_valid is low is ignored.
  - cmd_ready held low indefinitely stalls the block; busy stays high, no acks are issued.
  - A request deasserted before it is granted is simply never granted; no error.
- busy = (state != IDLE).

Decomposition:
- Package ddr_arb_pkg holds:
  - state enum {IDLE, ISSUE};
  - grant encoding constants GNT_WR=1'b1, GNT_RD=1'b0;
  - default values for WR_BURST_MAX and RD_BURST_MAX.
- One sub-module, ddr_arb_policy, holds the streak counters and the combinational winner select. Its inputs are req, last_grant and the grant strobe; its output is the winner.
- The top level holds the FSM and the cmd registers.

Test Plan:
1. Lone write, cmd_ready=1: wr_req with adx=0x0000010, data=0xA5…A5.
   - -> cycle+1: cmd_valid=1, cmd_write=1, cmd_adx=0x10, wr_ack=1 for 1 cycle.
   - -> cycle+2: cmd_valid=0.
2. Backpressure: rd_req with adx=0x40, cmd_ready=0 for 5 cycles.
   - -> cmd_valid and cmd_adx stable for 5 cycles, rd_ack pulses once.
   - -> IDLE the cycle after cmd_ready=1.
3. Write starvation limit: wr_req and rd_req held continuously, WR_BURST_MAX=8, RD_BURST_MAX=2.
   - -> grant sequence W×8, R×2, W×8, R×2.
4. Reads only: rd_req held with incrementing rd_adx 0..3.
   - -> 4 reads issued, rd_streak stays 0 since wr_req is low, no forced writes.
5. Async reset asserted mid-ISSUE while cmd_ready=0.
   - -> cmd_valid, acks and busy drop immediately without a clock edge; counters=0.
   - -> after release with reqs low, block stays in IDLE.
6. Request withdrawn: rd_req high for 1 cycle while a write is in ISSUE, then low.
   - -> no rd_ack, no read command issued.
